// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - client-side bus of the two-port ALU arbiter
// Purpose: bundles both clients' request/operand signals and the shared
//          ack/result/status signals returned by the arbiter.
// Signals:
//   req0/req1            client request, held until the matching ack
//   a0,b0,op0/a1,b1,op1  signed 4-bit operands and 2-bit opcode per client
//   ack0/ack1            one-cycle completion pulse per client
//   result               registered signed 4-bit ALU result
//   busy                 arbiter is in EXEC or DONE
//   ops_count            completed-operation count, wraps at 256
// Modports: master = client/driver side, slave = arbiter side.

interface alu_arbiter_if;
    logic              req0;
    logic              req1;
    logic signed [3:0] a0;
    logic signed [3:0] b0;
    logic [1:0]        op0;
    logic signed [3:0] a1;
    logic signed [3:0] b1;
    logic [1:0]        op1;
    logic              ack0;
    logic              ack1;
    logic signed [3:0] result;
    logic              busy;
    logic [7:0]        ops_count;

    modport master (
        output req0, req1, a0, b0, op0, a1, b1, op1,
        input  ack0, ack1, result, busy, ops_count
    );

    modport slave (
        input  req0, req1, a0, b0, op0, a1, b1, op1,
        output ack0, ack1, result, busy, ops_count
    );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin two-client sequencer for a shared 4-bit ALU
// Purpose: grants one of two requesters, latches its operands, runs the
//          shared combinational ALU for one cycle, registers the result and
//          pulses the owner's ack.  Contains the alu and alu_arbiter modules.
// Ports (alu_arbiter):
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_arbiter_if.slave (requests/operands in, ack/result/status out)
// Ports (alu):
//   i0, i1 signed 4-bit operands; op 2-bit opcode; y signed 4-bit result
//   (00 add, 01 subtract, 10 and, 11 or; two's complement wrap)

module alu (
    input  logic signed [3:0] i0,
    input  logic signed [3:0] i1,
    input  logic [1:0]        op,
    output logic signed [3:0] y
);
    always_comb begin
        y = 4'sd0;
        case (op)
            2'b00:   y = i0 + i1;
            2'b01:   y = i0 - i1;
            2'b10:   y = i0 & i1;
            default: y = i0 | i1;
        endcase
    end
endmodule

module alu_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;

    logic signed [3:0] opnd_a;
    logic signed [3:0] opnd_b;
    logic [1:0]        opnd_op;
    logic              owner;
    logic              last_grant;
    logic signed [3:0] result_q;
    logic              ack0_q;
    logic              ack1_q;
    logic              busy_q;
    logic [7:0]        ops_count_q;

    logic              grant;
    logic              grant_id;
    logic signed [3:0] alu_y;

    // The ALU only ever sees the latched operands, so client operand
    // changes after the grant edge cannot disturb the in-flight operation.
    alu u_alu (
        .i0 (opnd_a),
        .i1 (opnd_b),
        .op (opnd_op),
        .y  (alu_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        grant      = 1'b0;
        grant_id   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req0 && bus.req1) begin
                    // Contention: the client that did not win last time goes.
                    grant    = 1'b1;
                    grant_id = ~last_grant;
                end else if (bus.req0) begin
                    grant    = 1'b1;
                    grant_id = 1'b0;
                end else if (bus.req1) begin
                    grant    = 1'b1;
                    grant_id = 1'b1;
                end
                if (grant) begin
                    next_state = EXEC;
                end
            end
            EXEC:    next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opnd_a      <= 4'sd0;
            opnd_b      <= 4'sd0;
            opnd_op     <= 2'b00;
            owner       <= 1'b0;
            last_grant  <= 1'b1;
            result_q    <= 4'sd0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            busy_q      <= 1'b0;
            ops_count_q <= 8'd0;
        end else begin
            if (grant) begin
                opnd_a     <= grant_id ? bus.a1  : bus.a0;
                opnd_b     <= grant_id ? bus.b1  : bus.b0;
                opnd_op    <= grant_id ? bus.op1 : bus.op0;
                owner      <= grant_id;
                last_grant <= grant_id;
            end

            // Acks are set on the edge leaving EXEC so they are high for
            // exactly the DONE cycle, together with the new result.
            if (state == EXEC) begin
                result_q <= alu_y;
                ack0_q   <= ~owner;
                ack1_q   <= owner;
            end else begin
                ack0_q   <= 1'b0;
                ack1_q   <= 1'b0;
            end

            if (state == DONE) begin
                ops_count_q <= ops_count_q + 8'd1;
            end

            busy_q <= (next_state != IDLE);
        end
    end

    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.result    = result_q;
    assign bus.busy      = busy_q;
    assign bus.ops_count = ops_count_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter

module tb_alu_arbiter;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    logic       m_last;
    logic [7:0] m_count;

    alu_arbiter_if bus ();

    alu_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, expected finish before 400000");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [3:0] ref_alu(logic [3:0] a, logic [3:0] b, logic [1:0] op);
        int ia;
        int ib;
        int r;
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            2'd0:    r = ia + ib;
            2'd1:    r = ia - ib;
            2'd2:    r = ia & ib;
            default: r = ia | ib;
        endcase
        return r[3:0];
    endfunction

    task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_client(int c, logic r, logic [3:0] a, logic [3:0] b, logic [1:0] op);
        if (c == 0) begin
            bus.req0 = r; bus.a0 = a; bus.b0 = b; bus.op0 = op;
        end else begin
            bus.req1 = r; bus.a1 = a; bus.b1 = b; bus.op1 = op;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_last  = 1'b1;
        m_count = 8'd0;
    endtask

    // One isolated request; optional operand change once the op is granted.
    task automatic single_op(int c, logic [3:0] a, logic [3:0] b, logic [1:0] op,
                             bit perturb, logic [3:0] a_new);
        int         cyc;
        bit         got;
        logic [3:0] exp_r;
        @(negedge clk);
        drive_client(c, 1'b1, a, b, op);
        exp_r = ref_alu(a, b, op);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check("busy_exec", {7'd0, bus.busy}, 8'd1);
                if (perturb) drive_client(c, 1'b1, a_new, b, op);
            end
            if (bus.ack0 || bus.ack1) got = 1'b1;
        end
        check("ack_seen", {7'd0, got}, 8'd1);
        check("ack_latency", cyc[7:0], 8'd2);
        check("ack_owner", {6'd0, bus.ack1, bus.ack0}, (c == 0) ? 8'd1 : 8'd2);
        check("result", {4'd0, bus.result}, {4'd0, exp_r});
        drive_client(c, 1'b0, a, b, op);
        m_count++;
        m_last = c[0];
        @(negedge clk);
        check("ops_count", bus.ops_count, m_count);
        check("idle_after", {6'd0, bus.busy, bus.ack0 | bus.ack1}, 8'd0);
    endtask

    // Both clients request; each re-requests in the IDLE cycle after its ack.
    task automatic contend(int n_ops);
        logic [3:0] ca [2];
        logic [3:0] cb [2];
        logic [1:0] cop [2];
        bit         pend [2];
        int         done_ops;
        int         cyc;
        int         last_ack;
        int         got;
        int         exp_g;
        int         npend;
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            ca[c]  = 4'($urandom);
            cb[c]  = 4'($urandom);
            cop[c] = 2'($urandom);
            pend[c] = 1'b1;
            drive_client(c, 1'b1, ca[c], cb[c], cop[c]);
        end
        done_ops = 0;
        cyc = 0;
        last_ack = -1;
        while (done_ops < n_ops && cyc < 20 * n_ops + 10) begin
            @(negedge clk);
            cyc++;
            if (bus.ack0 || bus.ack1) begin
                check("ack_overlap", {7'd0, bus.ack0 & bus.ack1}, 8'd0);
                got = bus.ack1 ? 1 : 0;
                if (pend[0] && pend[1]) exp_g = m_last ? 0 : 1;
                else exp_g = pend[0] ? 0 : 1;
                check("grant_order", got[7:0], exp_g[7:0]);
                check("cont_result", {4'd0, bus.result},
                      {4'd0, ref_alu(ca[exp_g], cb[exp_g], cop[exp_g])});
                if (last_ack >= 0) check("ack_gap", 8'(cyc - last_ack), 8'd3);
                last_ack = cyc;
                m_last = exp_g[0];
                m_count++;
                done_ops++;
                pend[got] = 1'b0;
                drive_client(got, 1'b0, ca[got], cb[got], cop[got]);
            end else begin
                npend = int'(pend[0]) + int'(pend[1]);
                for (int c = 0; c < 2; c++) begin
                    if (!pend[c] && npend < n_ops - done_ops) begin
                        ca[c]  = 4'($urandom);
                        cb[c]  = 4'($urandom);
                        cop[c] = 2'($urandom);
                        pend[c] = 1'b1;
                        npend++;
                        drive_client(c, 1'b1, ca[c], cb[c], cop[c]);
                    end
                end
            end
        end
        check("cont_done", done_ops[7:0], n_ops[7:0]);
        @(negedge clk);
        check("cont_count", bus.ops_count, m_count);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        bus.req0 = 1'b0; bus.a0 = 4'd0; bus.b0 = 4'd0; bus.op0 = 2'd0;
        bus.req1 = 1'b0; bus.a1 = 4'd0; bus.b1 = 4'd0; bus.op1 = 2'd0;
        m_last   = 1'b1;
        m_count  = 8'd0;

        repeat (3) @(negedge clk);
        check("rst_result", {4'd0, bus.result}, 8'd0);
        check("rst_acks", {6'd0, bus.ack1, bus.ack0}, 8'd0);
        check("rst_busy", {7'd0, bus.busy}, 8'd0);
        check("rst_count", bus.ops_count, 8'd0);
        rst_n = 1'b1;

        single_op(0, 4'd3, 4'd2, 2'b00, 1'b0, 4'd0);
        single_op(1, 4'd7, 4'd1, 2'b00, 1'b0, 4'd0);
        single_op(0, 4'b1000, 4'd1, 2'b01, 1'b0, 4'd0);

        do_reset();
        contend(6);
        check("cont6_count", bus.ops_count, 8'd6);

        single_op(0, 4'd2, 4'd3, 2'b10, 1'b1, 4'd7);
        single_op(0, 4'd5, 4'd2, 2'b11, 1'b0, 4'd0);

        // Reset while the operation is executing.
        @(negedge clk);
        drive_client(0, 1'b1, 4'd1, 4'd1, 2'b00);
        @(negedge clk);
        check("mid_busy", {7'd0, bus.busy}, 8'd1);
        rst_n = 1'b0;
        #1;
        check("mid_result", {4'd0, bus.result}, 8'd0);
        check("mid_acks", {6'd0, bus.ack1, bus.ack0}, 8'd0);
        check("mid_count", bus.ops_count, 8'd0);
        check("mid_busy_rst", {7'd0, bus.busy}, 8'd0);
        @(negedge clk);
        drive_client(0, 1'b0, 4'd1, 4'd1, 2'b00);
        rst_n = 1'b1;
        m_last  = 1'b1;
        m_count = 8'd0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_idle", {6'd0, bus.busy, bus.ack0 | bus.ack1}, 8'd0);
        end

        for (int i = 0; i < 256; i++) begin
            single_op(int'($urandom_range(1, 0)), 4'($urandom), 4'($urandom),
                      2'($urandom), 1'b0, 4'd0);
        end
        check("wrap_count", bus.ops_count, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
